// File: rtl/divider_pkg.sv
// Shared FSM encoding and round-robin helper for the divider arbiter.
package divider_pkg;

  typedef enum logic [2:0] {
    ARB       = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_e;

  // Pointer to the requester after id, wrapping to 0 past n-1.
  function automatic int unsigned rr_advance(input int unsigned id, input int unsigned n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/divider_arbiter_if.sv
// Requester-facing bus of the divider arbiter: flat operand buses plus result return.
interface divider_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] dividend_in;
  logic [N_REQ*WIDTH-1:0] divisor_in;
  logic [N_REQ-1:0]       ack;
  logic                   res_valid;
  logic [ID_W-1:0]        res_id;
  logic [WIDTH-1:0]       quotient;
  logic [WIDTH-1:0]       remainder;
  logic                   div_err;
  logic                   busy;

  modport master (
    output req, dividend_in, divisor_in,
    input  ack, res_valid, res_id, quotient, remainder, div_err, busy
  );

  modport slave (
    input  req, dividend_in, divisor_in,
    output ack, res_valid, res_id, quotient, remainder, div_err, busy
  );
endinterface

// File: rtl/divider_param.sv
// Sequential restoring divider: one quotient bit per cycle, WIDTH cycles per operation.
module divider_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             idle,
  output logic             not_valid
);

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   diff_c;

  // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
  assign shifted_c = {acc[WIDTH-1:0], quotient[WIDTH-1]};
  assign diff_c    = shifted_c - {1'b0, dvs};
  assign remainder = acc[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      idle      <= 1'b1;
      not_valid <= 1'b0;
    end else if (idle) begin
      if (strt) begin
        acc       <= '0;
        dvs       <= divisor;
        quotient  <= dividend;
        cnt       <= CNT_W'(WIDTH - 1);
        idle      <= 1'b0;
        not_valid <= (divisor == '0);
      end
    end else begin
      if (!diff_c[WIDTH]) begin
        acc      <= diff_c;
        quotient <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        acc      <= shifted_c;
        quotient <= {quotient[WIDTH-2:0], 1'b0};
      end
      if (cnt == '0) idle <= 1'b1;
      else           cnt  <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one sequential divider among N_REQ requesters.
module divider_arbiter
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  divider_arbiter_if.slave  bus
);

  state_e           state;
  state_e           state_d;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  idx_c;
  logic [ID_W-1:0]  grant_id_c;
  logic             grant_c;
  logic [WIDTH-1:0] op_dvd;
  logic [WIDTH-1:0] op_dvs;
  logic             strt;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             div_idle;
  logic             div_nv;

  // First pending requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_c    = 1'b0;
    grant_id_c = '0;
    idx_c      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx_c = ID_W'((32'(rr_ptr) + k) % N_REQ);
      if (!grant_c && bus.req[idx_c]) begin
        grant_c    = 1'b1;
        grant_id_c = idx_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ARB:       if (grant_c)   state_d = LAUNCH;
      LAUNCH:                   state_d = WAIT_BUSY;
      WAIT_BUSY: if (!div_idle) state_d = WAIT_DONE;
      WAIT_DONE: if (div_idle)  state_d = RESP;
      RESP:                     state_d = ARB;
      default:                  state_d = ARB;
    endcase
  end

  // Operand capture, handshake pulses and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      cur_id        <= '0;
      op_dvd        <= '0;
      op_dvs        <= '0;
      strt          <= 1'b0;
      bus.ack       <= '0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.ack       <= '0;
      bus.res_valid <= 1'b0;
      strt          <= 1'b0;
      bus.busy      <= (state_d != ARB);
      if (state == ARB && grant_c) begin
        cur_id  <= grant_id_c;
        op_dvd  <= bus.dividend_in[32'(grant_id_c)*WIDTH +: WIDTH];
        op_dvs  <= bus.divisor_in[32'(grant_id_c)*WIDTH +: WIDTH];
        bus.ack <= N_REQ'(1) << grant_id_c;
        strt    <= 1'b1;
      end
      if (state == WAIT_DONE && div_idle) begin
        bus.quotient  <= div_q;
        bus.remainder <= div_r;
        bus.div_err   <= div_nv;
        bus.res_id    <= cur_id;
        bus.res_valid <= 1'b1;
      end
      if (state == RESP) rr_ptr <= ID_W'(rr_advance(32'(cur_id), N_REQ));
    end
  end

  divider_param #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .strt      (strt),
    .dividend  (op_dvd),
    .divisor   (op_dvs),
    .quotient  (div_q),
    .remainder (div_r),
    .idle      (div_idle),
    .not_valid (div_nv)
  );

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed self-checking bench for divider_arbiter.
module tb_divider_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_rv;

  divider_arbiter_if #(.WIDTH(32), .N_REQ(4), .ID_W(2)) bus ();

  divider_arbiter #(.WIDTH(32), .CNT_W(5), .N_REQ(4), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] dvd, input logic [31:0] dvs);
    bus.dividend_in[i*32 +: 32] = dvd;
    bus.divisor_in[i*32 +: 32]  = dvs;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int exp_id, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack == '0 && n < 100);
    check({tag, "_ack"}, 64'(bus.ack), 64'(1) << exp_id);
    check({tag, "_no_rv_at_ack"}, 64'(bus.res_valid), 64'(0));
  endtask

  task automatic wait_res(input int exp_id, input logic [31:0] q, input logic [31:0] r,
                          input logic e, input bit chk_qr, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.res_valid && n < 200);
    check({tag, "_res_valid"}, 64'(bus.res_valid), 64'(1));
    check({tag, "_no_ack_at_rv"}, 64'(bus.ack), 64'(0));
    check({tag, "_res_id"}, 64'(bus.res_id), 64'(exp_id));
    check({tag, "_div_err"}, 64'(bus.div_err), 64'(e));
    if (chk_qr) begin
      check({tag, "_quotient"}, 64'(bus.quotient), 64'(q));
      check({tag, "_remainder"}, 64'(bus.remainder), 64'(r));
    end
  endtask

  logic [31:0] t_dvd [4] = '{32'd100, 32'd201, 32'd302, 32'd403};
  logic [31:0] t_dvs [4] = '{32'd3, 32'd4, 32'd5, 32'd6};
  logic [31:0] t_q   [4] = '{32'd33, 32'd50, 32'd60, 32'd67};
  logic [31:0] t_r   [4] = '{32'd1, 32'd1, 32'd2, 32'd1};

  initial begin
    bus.req         = '0;
    bus.dividend_in = '0;
    bus.divisor_in  = '0;

    // Reset values
    tick();
    tick();
    check("rst_ack", 64'(bus.ack), 64'(0));
    check("rst_res_valid", 64'(bus.res_valid), 64'(0));
    check("rst_res_id", 64'(bus.res_id), 64'(0));
    check("rst_quotient", 64'(bus.quotient), 64'(0));
    check("rst_remainder", 64'(bus.remainder), 64'(0));
    check("rst_div_err", 64'(bus.div_err), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    rst = 1'b0;
    tick();
    check("idle_busy", 64'(bus.busy), 64'(0));

    // Single request, exact division
    set_ops(0, 32'd12339, 32'd9);
    bus.req = 4'b0001;
    wait_ack(0, "t1");
    bus.req = 4'b0000;
    tick();
    check("t1_busy", 64'(bus.busy), 64'(1));
    wait_res(0, 32'd1371, 32'd0, 1'b0, 1'b1, "t1");
    tick();
    check("t1_rv_pulse", 64'(bus.res_valid), 64'(0));
    check("t1_q_hold", 64'(bus.quotient), 64'(1371));
    check("t1_busy_after", 64'(bus.busy), 64'(0));

    // Simultaneous requests 0 and 2
    do_reset();
    set_ops(0, 32'd100, 32'd7);
    set_ops(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.req = 4'b0101;
    wait_ack(0, "t2a");
    bus.req = 4'b0100;
    wait_res(0, 32'd14, 32'd2, 1'b0, 1'b1, "t2a");
    wait_ack(2, "t2b");
    bus.req = 4'b0000;
    wait_res(2, 32'd1, 32'd0, 1'b0, 1'b1, "t2b");

    // All requesters held: round-robin 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, t_dvd[i], t_dvs[i]);
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ack(j % 4, $sformatf("t3_%0d", j));
      wait_res(j % 4, t_q[j % 4], t_r[j % 4], 1'b0, 1'b1, $sformatf("t3_%0d", j));
    end
    bus.req = 4'b0000;

    // Divide by zero
    set_ops(1, 32'h0ABC_6310, 32'd0);
    bus.req = 4'b0010;
    wait_ack(1, "t4");
    bus.req = 4'b0000;
    wait_res(1, 32'd0, 32'd0, 1'b1, 1'b0, "t4");

    // Reset mid-operation, then a fresh request
    set_ops(3, 32'd1000, 32'd3);
    bus.req = 4'b1000;
    wait_ack(3, "t5a");
    bus.req = 4'b0000;
    repeat (10) tick();
    check("t5_busy_mid", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 64'(bus.busy), 64'(0));
    check("t5_rst_res_id", 64'(bus.res_id), 64'(0));
    check("t5_rst_div_err", 64'(bus.div_err), 64'(0));
    check("t5_rst_quotient", 64'(bus.quotient), 64'(0));
    check("t5_rst_remainder", 64'(bus.remainder), 64'(0));
    tick();
    rst = 1'b0;
    n_rv = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (bus.res_valid || bus.ack != '0) n_rv++;
    end
    check("t5_no_stale_result", 64'(n_rv), 64'(0));
    set_ops(3, 32'd120, 32'd11);
    bus.req = 4'b1000;
    wait_ack(3, "t5b");
    bus.req = 4'b0000;
    wait_res(3, 32'd10, 32'd10, 1'b0, 1'b1, "t5b");

    // Operand change after ack has no effect
    set_ops(0, 32'd500, 32'd7);
    bus.req = 4'b0001;
    wait_ack(0, "t6");
    set_ops(0, 32'd9, 32'd3);
    bus.req = 4'b0000;
    wait_res(0, 32'd71, 32'd3, 1'b0, 1'b1, "t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result bit width.
REQ-002 Parameter CNT_W, default 5, log2(WIDTH); passed to divider sub-module.
REQ-003 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-004 Parameter ID_W, default 2, requester id width, log2(N_REQ).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req  in  N_REQ  per-requester division request, level, held until ack.
REQ-008 dividend_in  in  N_REQ*WIDTH  flat bus, slice i belongs to requester i.
REQ-009 divisor_in  in  N_REQ*WIDTH  flat bus, slice i belongs to requester i.
REQ-010 ack  out  N_REQ  one-hot, one-cycle pulse: operands of requester i captured.
REQ-011 res_valid  out  1  one-cycle pulse: result outputs valid.
REQ-012 res_id  out  ID_W  requester id owning the current result.
REQ-013 quotient  out  WIDTH  registered quotient.
REQ-014 remainder  out  WIDTH  registered remainder.
REQ-015 div_err  out  1  registered divide-by-zero flag (divider not_valid).
REQ-016 busy  out  1  high in every state except ARB.

Function
REQ-017 FSM states ARB, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP.
REQ-018 ARB: if any req bit set, grant the first set bit at or after rr_ptr (wrapping modulo N_REQ), capture its operands and id, pulse ack[id], go to LAUNCH; else stay.
REQ-019 LAUNCH: drive divider strt high exactly one cycle with captured operands, go to WAIT_BUSY.
REQ-020 WAIT_BUSY: on divider idle low go to WAIT_DONE; stay otherwise.
REQ-021 WAIT_DONE: on divider idle high, register quotient, remainder, not_valid into outputs, go to RESP.
REQ-022 RESP: res_valid high one cycle with res_id; rr_ptr <= id+1 (wrap to 0 after N_REQ-1); return to ARB.
REQ-023 Operands to the divider come only from internal capture registers; input changes after ack have no effect on the running operation.
REQ-024 Requester dropping req after ack does not abort; its result is still delivered.
REQ-025 A req bit still high in ARB after its own RESP is a new request; re-granted only when no other requester ahead of it in rr order is pending.
REQ-026 Minimum spacing between two acks: LAUNCH + divider latency + RESP; never two operations in flight.
REQ-027 Divisor zero: operation runs normally; div_err=1 in RESP; quotient/remainder passed through unmodified from the divider.
REQ-028 quotient, remainder, div_err, res_id hold value until next RESP.
REQ-029 ack and res_valid never high in the same cycle.

Reset
REQ-030 On rst: state ARB, rr_ptr 0, ack 0, res_valid 0, res_id 0, quotient 0, remainder 0, div_err 0, busy 0, strt 0.
REQ-031 rst also resets the divider sub-module; reset mid-operation discards the operation, no ack/res_valid for it.
REQ-032 After rst release, first grant occurs on the first clock edge with req nonzero.

Structure
REQ-033 State encoding and rr-advance helper in shared package divider_pkg.
REQ-034 One sub-module: divider_param #(WIDTH, CNT_W), sharing clk and rst.

Verification
REQ-035 req=0001, 12339/9 -> ack[0], later res_valid, res_id 0, quotient 1371, remainder 0, div_err 0.
REQ-036 req=0101 simultaneous, 100/7 and 0xFFFFFFFF/0xFFFFFFFF -> grant 0 first (14 r 2), then 2 (1 r 0).
REQ-037 All four req held high continuously -> ack order 0,1,2,3,0; each res_id matches preceding ack.
REQ-038 req=0010, 0x0ABC6310/0 -> res_valid with res_id 1, div_err 1.
REQ-039 rst asserted during WAIT_DONE -> all outputs zero immediately; no res_valid; next request completes correctly.
REQ-040 Operand inputs changed the cycle after ack -> result reflects captured operands.
